// File: rtl/encoder_event_decoder.sv
// Decodes rotary-encoder quadrature and push-button changes from debounced
// input snapshots into a small first-word fall-through event FIFO.
module encoder_event_decoder #(
  parameter int ENCODER_COUNT     = 5,
  parameter int INPUT_BITS        = 16,
  parameter int FIFO_DEPTH_BITS   = 4,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INPUT_BITS-1:0] DEBOUNCED,
  input  logic                  UPDATED,
  output logic                  EVENT_VALID,
  input  logic                  EVENT_READY,
  output logic [2:0]            EVENT_ENCODER,
  output logic [1:0]            EVENT_TYPE,
  output logic                  OVERFLOW,
  input  logic                  CLEAR_OVERFLOW,
  output logic                  BUSY
);

  localparam int USED_BITS  = 3 * ENCODER_COUNT;
  localparam int PTR_W      = FIFO_DEPTH_BITS + 1;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;

  localparam logic [1:0] EV_CW      = 2'd0;
  localparam logic [1:0] EV_CCW     = 2'd1;
  localparam logic [1:0] EV_PRESS   = 2'd2;
  localparam logic [1:0] EV_RELEASE = 2'd3;

  localparam logic [2:0] LAST_IDX = 3'(ENCODER_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN_ROT,
    ST_SCAN_BTN,
    ST_FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [USED_BITS-1:0]   prev_q, prev_d;
  logic [USED_BITS-1:0]   cur_q, cur_d;
  logic [USED_BITS-1:0]   pend_q, pend_d;
  logic                   pend_valid_q, pend_valid_d;

  logic                   push_s;
  logic [4:0]             push_data_s;

  logic [1:0]             sel_prev_ab_s, sel_cur_ab_s;
  logic                   sel_prev_btn_s, sel_cur_btn_s;
  logic [1:0]             rot_s;

  logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic                   ovf_q, ovf_d;
  logic [4:0]             mem_q [FIFO_DEPTH];
  logic                   empty_s, full_s, pop_s, do_write_s, drop_s;
  logic [4:0]             head_s;

  // Bits beyond the last encoder carry no meaning for this block.
  generate
    if (INPUT_BITS > USED_BITS) begin : g_upper
      logic unused_upper_s;
      assign unused_upper_s = ^DEBOUNCED[INPUT_BITS-1:USED_BITS];
    end
  endgenerate

  // Returns {push, ccw} for one quadrature step; skipped steps yield no push.
  function automatic logic [1:0] rot_decode(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rot_decode = 2'b10;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rot_decode = 2'b11;
      default:                                rot_decode = 2'b00;
    endcase
  endfunction

  // Select the lines of the encoder currently being scanned.
  always_comb begin
    sel_prev_ab_s  = 2'b00;
    sel_cur_ab_s   = 2'b00;
    sel_prev_btn_s = 1'b0;
    sel_cur_btn_s  = 1'b0;
    for (int e = 0; e < ENCODER_COUNT; e++) begin
      if (idx_q == 3'(e)) begin
        sel_prev_ab_s  = {prev_q[3*e+1], prev_q[3*e]};
        sel_cur_ab_s   = {cur_q[3*e+1], cur_q[3*e]};
        sel_prev_btn_s = prev_q[3*e+2];
        sel_cur_btn_s  = cur_q[3*e+2];
      end else begin
        sel_prev_ab_s  = sel_prev_ab_s;
        sel_cur_ab_s   = sel_cur_ab_s;
        sel_prev_btn_s = sel_prev_btn_s;
        sel_cur_btn_s  = sel_cur_btn_s;
      end
    end
    rot_s = rot_decode(sel_prev_ab_s, sel_cur_ab_s);
  end

  // Scan FSM next-state, snapshot handling and event generation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    prev_d       = prev_q;
    cur_d        = cur_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    push_s       = 1'b0;
    push_data_s  = 5'd0;

    if (UPDATED && (state_q != ST_IDLE)) begin
      pend_d       = DEBOUNCED[USED_BITS-1:0];
      pend_valid_d = 1'b1;
    end else begin
      pend_d       = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (UPDATED) begin
          cur_d   = DEBOUNCED[USED_BITS-1:0];
          idx_d   = 3'd0;
          state_d = ST_SCAN_ROT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN_ROT: begin
        if (rot_s[1]) begin
          push_s      = 1'b1;
          push_data_s = {idx_q, (rot_s[0] ? EV_CCW : EV_CW)};
        end else begin
          push_s      = 1'b0;
        end
        state_d = ST_SCAN_BTN;
      end
      ST_SCAN_BTN: begin
        if (sel_prev_btn_s != sel_cur_btn_s) begin
          push_s      = 1'b1;
          push_data_s = {idx_q, ((sel_cur_btn_s ^ BUTTON_ACTIVE_LOW) ? EV_PRESS : EV_RELEASE)};
        end else begin
          push_s      = 1'b0;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_SCAN_ROT;
        end
      end
      ST_FINISH: begin
        prev_d = cur_q;
        idx_d  = 3'd0;
        // A strobe landing on this very cycle is newer than anything pending.
        if (UPDATED) begin
          cur_d        = DEBOUNCED[USED_BITS-1:0];
          pend_valid_d = 1'b0;
          state_d      = ST_SCAN_ROT;
        end else if (pend_valid_q) begin
          cur_d        = pend_q;
          pend_valid_d = 1'b0;
          state_d      = ST_SCAN_ROT;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scan FSM and snapshot registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      prev_q       <= '0;
      cur_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      prev_q       <= prev_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign empty_s = (wr_q == rd_q);
  assign full_s  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                   (wr_q[PTR_W-2:0] == rd_q[PTR_W-2:0]);
  assign pop_s      = !empty_s && EVENT_READY;
  // When full, a simultaneous pop frees the very slot the write lands in.
  assign do_write_s = push_s && (!full_s || pop_s);
  assign drop_s     = push_s && full_s && !pop_s;

  // FIFO pointer and overflow next-state.
  always_comb begin
    wr_d = wr_q + PTR_W'(do_write_s);
    rd_d = rd_q + PTR_W'(pop_s);
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (CLEAR_OVERFLOW) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // Event storage; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (do_write_s) begin
      mem_q[wr_q[PTR_W-2:0]] <= push_data_s;
    end
  end

  assign head_s        = empty_s ? 5'd0 : mem_q[rd_q[PTR_W-2:0]];
  assign EVENT_VALID   = !empty_s;
  assign EVENT_ENCODER = head_s[4:2];
  assign EVENT_TYPE    = head_s[1:0];
  assign OVERFLOW      = ovf_q;
  assign BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_encoder_event_decoder.sv
// Directed bench for encoder_event_decoder with a queue-based event scoreboard.
module tb_encoder_event_decoder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] DEBOUNCED = 16'd0;
  logic        UPDATED = 1'b0;
  logic        EVENT_VALID;
  logic        EVENT_READY = 1'b0;
  logic [2:0]  EVENT_ENCODER;
  logic [1:0]  EVENT_TYPE;
  logic        OVERFLOW;
  logic        CLEAR_OVERFLOW = 1'b0;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  logic [4:0]  exp_q[$];
  logic [15:0] model_prev = 16'd0;
  bit          cap_en = 1'b0;

  encoder_event_decoder dut (
    .CLK(CLK), .RESET(RESET), .DEBOUNCED(DEBOUNCED), .UPDATED(UPDATED),
    .EVENT_VALID(EVENT_VALID), .EVENT_READY(EVENT_READY),
    .EVENT_ENCODER(EVENT_ENCODER), .EVENT_TYPE(EVENT_TYPE),
    .OVERFLOW(OVERFLOW), .CLEAR_OVERFLOW(CLEAR_OVERFLOW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Position of a quadrature code along the clockwise Gray sequence 00,01,11,10.
  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00: gpos = 0;
      2'b01: gpos = 1;
      2'b11: gpos = 2;
      default: gpos = 3;
    endcase
  endfunction

  task automatic add_ev(input int e, input logic [1:0] t);
    if (cap_en && exp_q.size() >= 16) begin
    end else begin
      exp_q.push_back({3'(e), t});
    end
  endtask

  task automatic scan_model(input logic [15:0] v);
    for (int e = 0; e < 5; e++) begin
      int d;
      d = (gpos({v[3*e+1], v[3*e]}) - gpos({model_prev[3*e+1], model_prev[3*e]}) + 4) % 4;
      if (d == 1) add_ev(e, 2'd0);
      else if (d == 3) add_ev(e, 2'd1);
      if (v[3*e+2] != model_prev[3*e+2]) add_ev(e, v[3*e+2] ? 2'd3 : 2'd2);
    end
    model_prev = v;
  endtask

  task automatic update(input logic [15:0] v);
    @(posedge CLK); #1;
    UPDATED = 1'b1; DEBOUNCED = v;
    @(posedge CLK); #1;
    UPDATED = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY && n < 100) begin
      @(negedge CLK); n++;
    end
    if (n >= 100) check({tag, "_idle_timeout"}, 16'(BUSY), 16'd0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || EVENT_VALID) && n < 200) begin
      @(negedge CLK); n++;
    end
    check({tag, "_drained"}, 16'(exp_q.size()), 16'd0);
    check({tag, "_valid_low"}, 16'(EVENT_VALID), 16'd0);
  endtask

  // Scoreboard: compare every accepted head event against the model queue.
  always @(negedge CLK) begin
    if (!RESET && EVENT_VALID && EVENT_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {11'd0, EVENT_ENCODER, EVENT_TYPE}, 16'hFFFF);
      end else begin
        check("event", {11'd0, EVENT_ENCODER, EVENT_TYPE}, {11'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int busy_cnt;
    int valid_cnt;

    // Reset state
    #1;
    check("rst_valid", 16'(EVENT_VALID), 16'd0);
    check("rst_ovf", 16'(OVERFLOW), 16'd0);
    check("rst_busy", 16'(BUSY), 16'd0);
    check("rst_head", {11'd0, EVENT_ENCODER, EVENT_TYPE}, 16'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    EVENT_READY = 1'b1;

    // Zero update: no events, scan of 11 cycles
    scan_model(16'h0000);
    update(16'h0000);
    busy_cnt = 0; valid_cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (BUSY) busy_cnt++;
      if (EVENT_VALID) valid_cnt++;
    end
    check("busy_cycles", 16'(busy_cnt), 16'd11);
    check("zero_no_valid", 16'(valid_cnt), 16'd0);

    // Encoder 0 CW with exact latency
    scan_model(16'h0001);
    @(posedge CLK); #1;
    UPDATED = 1'b1; DEBOUNCED = 16'h0001;
    @(negedge CLK); check("lat_t0", 16'(EVENT_VALID), 16'd0);
    @(posedge CLK); #1 UPDATED = 1'b0;
    @(negedge CLK); check("lat_t1", 16'(EVENT_VALID), 16'd0);
    @(negedge CLK); check("lat_t2", 16'(EVENT_VALID), 16'd1);
    @(negedge CLK); check("lat_t3", 16'(EVENT_VALID), 16'd0);
    wait_idle("cw");
    scan_model(16'h0000); update(16'h0000); wait_idle("ccw");

    // Skipped step on encoder 2, then button 4 release
    scan_model(16'h00C0); update(16'h00C0); wait_idle("skip");
    scan_model(16'h40C0); update(16'h40C0); wait_idle("btn4");
    wait_drain("basic");

    // All five encoders change at once; bit 15 alone changes nothing
    scan_model(16'h0000); update(16'h0000); wait_idle("prep");
    scan_model(16'h5B6D); update(16'h5B6D); wait_idle("all5");
    scan_model(16'hDB6D); update(16'hDB6D); wait_idle("bit15");
    wait_drain("all5");

    // Overflow: 20 events into a 16-deep FIFO with no consumer
    EVENT_READY = 1'b0;
    cap_en = 1'b1;
    scan_model(16'h0000); update(16'h0000); wait_idle("ovf1");
    scan_model(16'h5B6D); update(16'h5B6D); wait_idle("ovf2");
    cap_en = 1'b0;
    check("ovf_set", 16'(OVERFLOW), 16'd1);
    check("ovf_head", {11'd0, EVENT_ENCODER, EVENT_TYPE}, {11'd0, exp_q[0]});
    check("ovf_queued", 16'(exp_q.size()), 16'd16);
    @(posedge CLK); #1 CLEAR_OVERFLOW = 1'b1;
    @(posedge CLK); #1 CLEAR_OVERFLOW = 1'b0;
    @(negedge CLK); check("ovf_cleared", 16'(OVERFLOW), 16'd0);
    check("ovf_head_stable", {11'd0, EVENT_ENCODER, EVENT_TYPE}, {11'd0, exp_q[0]});
    EVENT_READY = 1'b1;
    wait_drain("ovf");

    // Pending: strobes at scan cycles 3 and 5, only the newest is rescanned
    scan_model(16'h0000);
    scan_model(16'h0009);
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge CLK); #1;
      UPDATED = (k == 0 || k == 4 || k == 6);
      DEBOUNCED = (k == 0) ? 16'h0000 : (k == 4) ? 16'h0002 : 16'h0009;
      @(negedge CLK);
      if (BUSY) busy_cnt++;
    end
    UPDATED = 1'b0;
    check("pend_busy_cycles", 16'(busy_cnt), 16'd22);
    wait_drain("pend");

    // Reset mid-scan with three events queued
    EVENT_READY = 1'b0;
    @(posedge CLK); #1 UPDATED = 1'b1; DEBOUNCED = 16'h0024;
    @(posedge CLK); #1 UPDATED = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pre_rst_valid", 16'(EVENT_VALID), 16'd1);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_valid", 16'(EVENT_VALID), 16'd0);
    check("mid_rst_ovf", 16'(OVERFLOW), 16'd0);
    check("mid_rst_busy", 16'(BUSY), 16'd0);
    exp_q.delete();
    model_prev = 16'h0000;
    @(posedge CLK); #1 RESET = 1'b0;
    EVENT_READY = 1'b1;
    scan_model(16'h0001); update(16'h0001); wait_idle("post_rst");
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_event_decoder.md
Name: encoder_event_decoder

Overview:
- Downstream consumer of the multiplexed debouncer output on the encoders board.
- Samples the debounced 16-bit input vector on each UPDATED pulse and treats it as ENCODER_COUNT rotary encoders, each with A, B and push-button lines.
- Compares each encoder's lines with the previous snapshot and turns valid changes into rotation and button events.
- Events are buffered in a small FIFO with a valid/ready interface towards the AXI register block / CPU side.

Parameters:
- ENCODER_COUNT, 5: number of encoders. Encoder i uses input bits 3i (A), 3i+1 (B) and 3i+2 (button). 3*ENCODER_COUNT must be <= INPUT_BITS.
- INPUT_BITS, 16: width of the debounced input vector.
- FIFO_DEPTH_BITS, 4: the FIFO holds 1<<FIFO_DEPTH_BITS events.
- BUTTON_ACTIVE_LOW, 1: when 1, a debounced 0 means pressed.

Ports:
- CLK, input, 1: clock, posedge.
- RESET, input, 1: asynchronous reset, active high.
- DEBOUNCED, input, INPUT_BITS: debounced input states. Valid only in the cycle UPDATED=1.
- UPDATED, input, 1: one-cycle strobe marking a new DEBOUNCED value.
- EVENT_VALID, output, 1: the FIFO head holds an event.
- EVENT_READY, input, 1: the consumer accepts the head event.
- EVENT_ENCODER, output, 3: encoder index of the head event.
- EVENT_TYPE, output, 2: 0=CW, 1=CCW, 2=PRESS, 3=RELEASE.
- OVERFLOW, output, 1: sticky flag; at least one event was dropped.
- CLEAR_OVERFLOW, input, 1: clears OVERFLOW.
- BUSY, output, 1: a scan is in progress.

Behaviour:
- Reset (asynchronous):
  - prev_snapshot = 0, cur_snapshot = 0.
  - FIFO empty, so EVENT_VALID = 0. EVENT_ENCODER and EVENT_TYPE are 0.
  - OVERFLOW = 0, BUSY = 0, pending = 0, FSM in IDLE.
  - Reset in the middle of a scan aborts the scan; events not yet pushed are lost.
- Capture:
  - UPDATED=1 in IDLE at cycle t: cur_snapshot <= DEBOUNCED, FSM -> SCAN with idx=0 at cycle t+1.
  - UPDATED=1 while not IDLE: DEBOUNCED is latched into a pending register and the pending flag is set. A later UPDATED overwrites it; the newest value wins.
- FSM states: IDLE, SCAN_ROT, SCAN_BTN, FINISH.
  - SCAN_ROT(idx): compare prev AB with cur AB for encoder idx.
    - CW transitions: 00->01, 01->11, 11->10, 10->00. Push {idx, CW}.
    - CCW transitions: the reverse of each CW transition. Push {idx, CCW}.
    - Unchanged AB, or both bits changed (skipped step): no push.
    - Next state is SCAN_BTN.
  - SCAN_BTN(idx): if the button bit changed, push {idx, PRESS} or {idx, RELEASE}. The active level is set by BUTTON_ACTIVE_LOW.
    - If idx = ENCODER_COUNT-1: go to FINISH. Otherwise idx++ and go to SCAN_ROT.
  - FINISH: prev_snapshot <= cur_snapshot.
    - If pending=1: cur_snapshot <= pending register, clear pending, go to SCAN_ROT with idx=0.
    - Otherwise go to IDLE.
- Scan timing:
  - A scan lasts 2*ENCODER_COUNT+1 cycles.
  - At most one push per cycle.
  - BUSY = 1 in every state except IDLE.
  - Input bits above 3*ENCODER_COUNT-1 are ignored.
- FIFO:
  - Synchronous, first-word fall-through.
  - A push becomes visible at EVENT_VALID on the next cycle. With UPDATED at cycle t and an encoder-0 rotation, EVENT_VALID=1 at cycle t+2.
  - Pop happens when EVENT_VALID and EVENT_READY are both 1.
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - Push when full with no pop: the event is dropped and OVERFLOW <= 1.
  - Pointers are FIFO_DEPTH_BITS+1 wide and wrap naturally. Full means the MSBs differ and the remaining bits are equal.
- Overflow flag:
  - CLEAR_OVERFLOW=1 clears OVERFLOW.
  - If a drop happens in the same cycle as CLEAR_OVERFLOW, the drop wins and OVERFLOW stays 1.
- The head outputs are stable while EVENT_VALID=1 and EVENT_READY=0.

Test Plan:
- Reset release, then UPDATED with DEBOUNCED=16'h0000 -> no event; BUSY high for 11 cycles; EVENT_VALID stays 0.
- Encoder 0 AB 00->01 (DEBOUNCED=16'h0001), EVENT_READY=1 -> one event {0, CW}; EVENT_VALID=1 exactly at t+2 for one cycle. Then 01->00 -> {0, CCW}.
- Encoder 2 AB 00->11 (bits 6 and 7 set) -> no rotation event. Button 4 bit 14 goes 0->1 with BUTTON_ACTIVE_LOW=1 -> {4, RELEASE}.
- Changes on all five encoders in one update (AB 00->01 and button 0->1 each) -> 10 events in order {0,CW}, {0,RELEASE}, {1,CW}, ..., {4,RELEASE}.
- EVENT_READY=0 and repeated updates producing 20 events with depth 16 -> 16 events retained, OVERFLOW=1. CLEAR_OVERFLOW -> 0. Draining returns the first 16 events in order.
- A second UPDATED arriving at scan cycle 3, then a third at cycle 5 -> one extra scan, using the third value only, starts immediately after FINISH.
- RESET asserted mid-scan with 3 events queued -> EVENT_VALID=0 and OVERFLOW=0 asynchronously. The next UPDATED is compared against a zero snapshot.
